// File: rtl/arm7tdmi_pkg.sv
// Shared definitions for the ARM7TDMI cache/MMU performance-monitor controller:
// register word addresses, register bit positions and the capture FSM state type.
package arm7tdmi_pkg;

  localparam int PERF_CTRL_A      = 'h00;
  localparam int PERF_CMD_A       = 'h01;
  localparam int PERF_STATUS_A    = 'h02;
  localparam int PERF_SEQ_A       = 'h03;
  localparam int PERF_AUTO_A      = 'h04;
  localparam int PERF_SNAP_BASE_A = 'h10;

  localparam int CTRL_EN_B       = 0;
  localparam int CTRL_IRQ_EN_B   = 1;
  localparam int CTRL_PERIOD_LSB = 4;
  localparam logic [7:0] CTRL_MASK = 8'hF3;

  localparam int CMD_RST_B  = 0;
  localparam int CMD_SNAP_B = 1;

  localparam int STAT_BUSY_B  = 0;
  localparam int STAT_VALID_B = 1;
  localparam int STAT_OVF_B   = 2;
  localparam int STAT_DROP_B  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } perf_ctrl_state_t;

endpackage

// File: rtl/arm7tdmi_perf_snap_buffer.sv
// Snapshot register file: one write port driven by the capture FSM, one
// combinational read port for register decode. Out-of-range reads return 0.
module arm7tdmi_perf_snap_buffer #(
  parameter int NUM_CNT = 17,
  parameter int SEL_W   = $clog2(NUM_CNT)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [SEL_W-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [SEL_W-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [NUM_CNT];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CNT; i++) mem_q[i] <= '0;
    end else if (we_i && (int'(waddr_i) < NUM_CNT)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = (int'(raddr_i) < NUM_CNT) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/arm7tdmi_perf_ctrl.sv
// Register-mapped controller for the cache/MMU performance monitor: config,
// atomic counter snapshot via external select mux, sticky overflow interrupt.
// Optional periodic auto-snapshot timer: define ARM7TDMI_PERF_AUTO_SNAPSHOT_EN.
module arm7tdmi_perf_ctrl
  import arm7tdmi_pkg::*;
#(
  parameter int NUM_CNT = 17,
  parameter int ADDR_W  = 6,
  parameter int SEL_W   = $clog2(NUM_CNT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ack,
  output logic              perf_enable,
  output logic              perf_reset,
  output logic [3:0]        perf_sample_period,
  output logic [SEL_W-1:0]  cnt_sel,
  input  logic [31:0]       cnt_data,
  input  logic              counters_overflow,
  output logic              irq
);

  // Bus handshake: a request is taken when cpu_req=1 and cpu_ack=0; the ack
  // follows one cycle later with registered read data, and writes land on
  // that same edge so they are visible during the ack cycle.
  perf_ctrl_state_t state_q, state_d;

  logic              ack_q;
  logic [31:0]       rdata_q;
  logic [7:0]        ctrl_q;
  logic              rst_pend_q, perf_reset_q;
  logic              snap_combo_q, snap_combo2_q;
  logic              ovf_prev_q, ovf_sticky_q, ovf_sticky_d;
  logic              drop_q, drop_d;
  logic              snap_valid_q;
  logic [31:0]       seq_q;
  logic [SEL_W-1:0]  sel_q;
  logic              busy, capturing;
  logic              sample, wr;
  logic              wr_ctrl, wr_cmd, wr_status;
  logic              snap_req, snap_drop, abort, ovf_rise;
  logic              in_snap;
  logic [SEL_W-1:0]  snap_ridx;
  logic [31:0]       buf_rdata, rd_val, auto_rd;
  logic              auto_fire;
  logic              unused_wdata;
  int                addr_int;

  assign addr_int  = int'(cpu_addr);
  assign sample    = cpu_req & ~ack_q;
  assign wr        = sample & cpu_we;
  assign wr_ctrl   = wr && (addr_int == PERF_CTRL_A);
  assign wr_cmd    = wr && (addr_int == PERF_CMD_A);
  assign wr_status = wr && (addr_int == PERF_STATUS_A);
  assign unused_wdata = ^cpu_wdata;

  // Reset+snapshot together defers the capture two edges so every word is post-reset.
  assign abort     = wr_cmd & cpu_wdata[CMD_RST_B] & busy;
  assign snap_req  = (wr_cmd & cpu_wdata[CMD_SNAP_B] & ~cpu_wdata[CMD_RST_B])
                   | snap_combo2_q | auto_fire;
  assign snap_drop = snap_req & busy;
  assign ovf_rise  = counters_overflow & ~ovf_prev_q;

  always_comb begin
    ovf_sticky_d = ovf_sticky_q;
    if (ovf_rise) ovf_sticky_d = 1'b1;
    else if (wr_status && cpu_wdata[STAT_OVF_B]) ovf_sticky_d = 1'b0;
  end

  always_comb begin
    drop_d = drop_q;
    if (snap_drop) drop_d = 1'b1;
    else if (wr_status && cpu_wdata[STAT_DROP_B]) drop_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q         <= 1'b0;
      rdata_q       <= '0;
      ctrl_q        <= '0;
      rst_pend_q    <= 1'b0;
      perf_reset_q  <= 1'b0;
      snap_combo_q  <= 1'b0;
      snap_combo2_q <= 1'b0;
      ovf_prev_q    <= 1'b0;
      ovf_sticky_q  <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      ack_q         <= sample;
      rdata_q       <= (sample && !cpu_we) ? rd_val : '0;
      if (wr_ctrl) ctrl_q <= cpu_wdata[7:0] & CTRL_MASK;
      rst_pend_q    <= wr_cmd & cpu_wdata[CMD_RST_B];
      perf_reset_q  <= rst_pend_q;
      snap_combo_q  <= wr_cmd & cpu_wdata[CMD_RST_B] & cpu_wdata[CMD_SNAP_B];
      snap_combo2_q <= snap_combo_q;
      ovf_prev_q    <= counters_overflow;
      ovf_sticky_q  <= ovf_sticky_d;
      drop_q        <= drop_d;
    end
  end

  // Capture FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Capture FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (snap_req) state_d = CAPTURE;
      CAPTURE: begin
        if (abort) state_d = IDLE;
        else if (sel_q == SEL_W'(NUM_CNT - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture FSM: outputs
  always_comb begin
    busy        = (state_q != IDLE);
    capturing   = (state_q == CAPTURE);
    cnt_sel     = capturing ? sel_q : '0;
    perf_enable = ctrl_q[CTRL_EN_B] & ~capturing;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q        <= '0;
      snap_valid_q <= 1'b0;
      seq_q        <= '0;
    end else begin
      sel_q <= (capturing && state_d == CAPTURE) ? sel_q + SEL_W'(1) : '0;
      if (state_q == IDLE && state_d == CAPTURE) snap_valid_q <= 1'b0;
      else if (state_q == DONE && !abort) snap_valid_q <= 1'b1;
      if (state_q == DONE && !abort) seq_q <= seq_q + 32'd1;
    end
  end

`ifdef ARM7TDMI_PERF_AUTO_SNAPSHOT_EN
  logic [31:0] auto_period_q, auto_cnt_q;
  logic        wr_auto, auto_run;

  assign wr_auto   = wr && (addr_int == PERF_AUTO_A);
  assign auto_run  = (auto_period_q != '0) && ctrl_q[CTRL_EN_B];
  assign auto_fire = auto_run && !wr_auto && (auto_cnt_q == auto_period_q - 32'd1);
  assign auto_rd   = auto_period_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_period_q <= '0;
      auto_cnt_q    <= '0;
    end else if (wr_auto) begin
      auto_period_q <= cpu_wdata;
      auto_cnt_q    <= '0;
    end else if (!auto_run || auto_fire) begin
      auto_cnt_q    <= '0;
    end else begin
      auto_cnt_q    <= auto_cnt_q + 32'd1;
    end
  end
`else
  assign auto_fire = 1'b0;
  assign auto_rd   = '0;
`endif

  assign in_snap   = (addr_int >= PERF_SNAP_BASE_A) && (addr_int < PERF_SNAP_BASE_A + NUM_CNT);
  assign snap_ridx = SEL_W'(addr_int - PERF_SNAP_BASE_A);

  always_comb begin
    rd_val = '0;
    if (addr_int == PERF_CTRL_A)        rd_val = {24'd0, ctrl_q};
    else if (addr_int == PERF_STATUS_A) rd_val = {28'd0, drop_q, ovf_sticky_q, snap_valid_q, busy};
    else if (addr_int == PERF_SEQ_A)    rd_val = seq_q;
    else if (addr_int == PERF_AUTO_A)   rd_val = auto_rd;
    else if (in_snap)                   rd_val = buf_rdata;
  end

  arm7tdmi_perf_snap_buffer #(
    .NUM_CNT (NUM_CNT),
    .SEL_W   (SEL_W)
  ) u_snap_buffer (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .we_i    (capturing),
    .waddr_i (sel_q),
    .wdata_i (cnt_data),
    .raddr_i (snap_ridx),
    .rdata_o (buf_rdata)
  );

  assign cpu_ack            = ack_q;
  assign cpu_rdata          = rdata_q;
  assign perf_reset         = perf_reset_q;
  assign perf_sample_period = ctrl_q[CTRL_PERIOD_LSB +: 4];
  assign irq                = ovf_sticky_q & ctrl_q[CTRL_IRQ_EN_B];

endmodule

// File: tb/tb_arm7tdmi_perf_ctrl.sv
// Directed bench for arm7tdmi_perf_ctrl: register reads are scored through an
// expected-data queue popped on cpu_ack; sideband outputs are checked directly.
module tb_arm7tdmi_perf_ctrl;

  localparam int NUM_CNT = 17;
  localparam int ADDR_W  = 6;
  localparam int SEL_W   = $clog2(NUM_CNT);

  logic              clk;
  logic              rst_n;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_ack;
  logic              perf_enable;
  logic              perf_reset;
  logic [3:0]        perf_sample_period;
  logic [SEL_W-1:0]  cnt_sel;
  logic [31:0]       cnt_data;
  logic              counters_overflow;
  logic              irq;

  logic [31:0] cnt_base;
  logic [31:0] exp_q[$];
  logic        chk_q[$];
  int          addr_q[$];
  int          n_vec;
  int          n_err;
  int          en_low_cnt;

  arm7tdmi_perf_ctrl #(
    .NUM_CNT (NUM_CNT),
    .ADDR_W  (ADDR_W),
    .SEL_W   (SEL_W)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .cpu_req            (cpu_req),
    .cpu_we             (cpu_we),
    .cpu_addr           (cpu_addr),
    .cpu_wdata          (cpu_wdata),
    .cpu_rdata          (cpu_rdata),
    .cpu_ack            (cpu_ack),
    .perf_enable        (perf_enable),
    .perf_reset         (perf_reset),
    .perf_sample_period (perf_sample_period),
    .cnt_sel            (cnt_sel),
    .cnt_data           (cnt_data),
    .counters_overflow  (counters_overflow),
    .irq                (irq)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External select mux model
  assign cnt_data = cnt_base + 32'(cnt_sel);

  always @(negedge clk) begin
    if (rst_n && !perf_enable) en_low_cnt <= en_low_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every ack pops one expected entry
  always @(negedge clk) begin
    if (rst_n && cpu_ack) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL ack_unexpected: got ack with no pending transaction at %0t", $time);
      end else begin
        logic [31:0] e;
        logic        c;
        int          a;
        e = exp_q.pop_front();
        c = chk_q.pop_front();
        a = addr_q.pop_front();
        if (c) begin
          n_vec++;
          if (cpu_rdata !== e) begin
            n_err++;
            $display("FAIL rdata addr 0x%0h: got %h expected %h at %0t", a, cpu_rdata, e, $time);
          end
        end
      end
    end
  end

  // Driver tasks: called at a negedge, return at a negedge two cycles later
  task automatic bus_xfer(input logic we, input int addr, input logic [31:0] wdata,
                          input logic [31:0] exp);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = ADDR_W'(addr);
    cpu_wdata = wdata;
    exp_q.push_back(exp);
    chk_q.push_back(!we);
    addr_q.push_back(addr);
    @(negedge clk);
    chk("ack_latency", {31'd0, cpu_ack}, 32'd1);
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_wr(input int addr, input logic [31:0] wdata);
    bus_xfer(1'b1, addr, wdata, 32'd0);
  endtask

  task automatic bus_rd(input int addr, input logic [31:0] exp);
    bus_xfer(1'b0, addr, 32'd0, exp);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int en0;
    n_vec = 0;
    n_err = 0;
    en_low_cnt = 0;
    cnt_base = 32'h1000;
    rst_n = 1'b0;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    counters_overflow = 1'b0;
    wait_n(3);
    rst_n = 1'b1;
    wait_n(1);

    // Reset state
    chk("rst_perf_enable", {31'd0, perf_enable}, 32'd0);
    chk("rst_perf_reset", {31'd0, perf_reset}, 32'd0);
    chk("rst_period", {28'd0, perf_sample_period}, 32'd0);
    chk("rst_cnt_sel", 32'(cnt_sel), 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_ack", {31'd0, cpu_ack}, 32'd0);
    bus_rd('h00, 32'h0);
    bus_rd('h02, 32'h0);
    bus_rd('h03, 32'h0);
    bus_rd('h10, 32'h0);

    // CTRL configuration
    bus_wr('h00, 32'h53);
    chk("ctrl_enable", {31'd0, perf_enable}, 32'd1);
    chk("ctrl_period", {28'd0, perf_sample_period}, 32'd5);
    chk("ctrl_irq_idle", {31'd0, irq}, 32'd0);
    bus_rd('h00, 32'h53);

    // Full snapshot; STATUS read sampled in the DONE cycle still shows busy
    cnt_base = 32'h1000;
    en0 = en_low_cnt;
    bus_wr('h01, 32'h2);
    wait_n(16);
    bus_rd('h02, 32'h1);
    chk("capture_enable_low", 32'(en_low_cnt - en0), 32'd17);
    chk("idle_cnt_sel", 32'(cnt_sel), 32'd0);
    for (int i = 0; i < NUM_CNT; i++) bus_rd('h10 + i, 32'h1000 + 32'(i));
    bus_rd('h02, 32'h2);
    bus_rd('h03, 32'h1);
    bus_rd('h01, 32'h0);
    bus_rd('h05, 32'h0);
    bus_rd('h21, 32'h0);
    bus_rd('h3F, 32'h0);

    // Snapshot request while busy is dropped
    cnt_base = 32'h3000;
    bus_wr('h01, 32'h2);
    wait_n(3);
    bus_wr('h01, 32'h2);
    wait_n(15);
    bus_rd('h02, 32'hA);
    bus_rd('h03, 32'h2);
    bus_rd('h10, 32'h3000);
    bus_rd('h20, 32'h3010);
    bus_wr('h02, 32'h8);
    bus_rd('h02, 32'h2);

    // Counter reset mid-capture aborts
    cnt_base = 32'h4000;
    bus_wr('h01, 32'h2);
    wait_n(6);
    bus_wr('h01, 32'h1);
    chk("abort_reset_pulse", {31'd0, perf_reset}, 32'd1);
    wait_n(1);
    chk("abort_reset_end", {31'd0, perf_reset}, 32'd0);
    chk("abort_cnt_sel", 32'(cnt_sel), 32'd0);
    chk("abort_enable", {31'd0, perf_enable}, 32'd1);
    bus_rd('h02, 32'h0);
    bus_rd('h03, 32'h2);

    // Reset and snapshot together: capture starts the cycle after the pulse
    cnt_base = 32'h2000;
    bus_wr('h01, 32'h3);
    chk("combo_reset_pulse", {31'd0, perf_reset}, 32'd1);
    chk("combo_enable_pre", {31'd0, perf_enable}, 32'd1);
    wait_n(1);
    chk("combo_reset_end", {31'd0, perf_reset}, 32'd0);
    chk("combo_enable_cap", {31'd0, perf_enable}, 32'd0);
    chk("combo_sel0", 32'(cnt_sel), 32'd0);
    wait_n(1);
    chk("combo_sel1", 32'(cnt_sel), 32'd1);
    wait_n(17);
    bus_rd('h02, 32'h2);
    bus_rd('h03, 32'h3);
    bus_rd('h10, 32'h2000);
    bus_rd('h20, 32'h2010);

    // Overflow interrupt, W1C, set-wins, irq_en gating
    counters_overflow = 1'b1;
    wait_n(1);
    chk("ovf_irq_set", {31'd0, irq}, 32'd1);
    bus_rd('h02, 32'h6);
    bus_wr('h02, 32'h4);
    chk("ovf_irq_clr", {31'd0, irq}, 32'd0);
    bus_rd('h02, 32'h2);
    counters_overflow = 1'b0;
    wait_n(2);
    counters_overflow = 1'b1;
    bus_wr('h02, 32'h4);
    chk("ovf_set_wins", {31'd0, irq}, 32'd1);
    bus_rd('h02, 32'h6);
    bus_wr('h00, 32'h51);
    chk("ovf_irq_gated", {31'd0, irq}, 32'd0);
    chk("ctrl_period_keep", {28'd0, perf_sample_period}, 32'd5);
    bus_rd('h02, 32'h6);

`ifdef ARM7TDMI_PERF_AUTO_SNAPSHOT_EN
    bus_wr('h04, 32'd100);
    bus_rd('h04, 32'd100);
    wait_n(326);
    bus_rd('h03, 32'h6);
    bus_wr('h04, 32'd0);
`else
    bus_wr('h04, 32'd100);
    bus_rd('h04, 32'h0);
`endif

    wait_n(3);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/arm7tdmi_perf_ctrl.md
Name: arm7tdmi_perf_ctrl

Overview:
- Register-mapped controller for the cache/MMU performance monitor.
- Configures the monitor: enable, sample period, counter reset.
- Sequences an atomic snapshot of all NUM_CNT counters through an external select mux into a local buffer, pausing counting during capture.
- Raises a sticky overflow interrupt. Sits between the CPU-side register bus and the monitor.

Parameters:
- NUM_CNT, 17, number of monitor counters captured (indices 0..NUM_CNT-1, monitor output order icache…mmu_asid_switches).
- ADDR_W, 6, register word-address width.
- SEL_W, $clog2(NUM_CNT), counter select width (derived).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  register transaction request
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  word address
- cpu_wdata  in  32  write data
- cpu_rdata  out  32  read data, valid with cpu_ack
- cpu_ack  out  1  one-cycle transaction acknowledge
- perf_enable  out  1  to monitor
- perf_reset  out  1  to monitor, one-cycle pulse
- perf_sample_period  out  4  to monitor
- cnt_sel  out  SEL_W  counter select to external mux
- cnt_data  in  32  selected counter value, combinational from mux
- counters_overflow  in  1  from monitor
- irq  out  1  overflow interrupt, level

Behaviour:
- Reset: all outputs 0; CTRL, STATUS, SNAP_SEQ and buffer cleared; state IDLE.
- Handshake:
  - Transaction is sampled when cpu_req=1 and cpu_ack=0.
  - cpu_ack=1 the next cycle, with registered cpu_rdata.
  - Writes take effect at the ack cycle. Requester drops or advances req after ack.
- Register map (word address):
  - 0x00 CTRL, RW: [0] enable, [1] irq_en, [7:4] sample_period.
  - 0x01 CMD, WO, reads 0: [0] reset counters, [1] snapshot request.
  - 0x02 STATUS: [0] busy RO, [1] snap_valid RO, [2] ovf_sticky W1C, [3] snap_dropped W1C.
  - 0x03 SNAP_SEQ, RO: 32-bit completed-snapshot count, wraps 0xFFFFFFFF→0.
  - 0x10+i, RO: snapshot word i, for i<NUM_CNT.
  - Unmapped reads return 0; unmapped writes are ignored.
- Output assignments:
  - perf_sample_period = CTRL[7:4].
  - perf_enable = CTRL[0] and state != CAPTURE. Events arriving during capture are not counted; this is by design.
- perf_reset: a CMD[0] write gives a 1-cycle pulse on the cycle after ack.
- FSM IDLE / CAPTURE / DONE:
  - IDLE→CAPTURE on snapshot request: snap_valid←0, cnt_sel←0.
  - CAPTURE: each cycle buf[cnt_sel]←cnt_data and cnt_sel increments. After index NUM_CNT-1 go to DONE. Capture occupies exactly NUM_CNT cycles.
  - DONE (1 cycle): snap_valid←1, SNAP_SEQ+1, →IDLE.
  - busy = state != IDLE. cnt_sel = 0 outside CAPTURE.
- Snapshot request while busy: dropped, snap_dropped←1.
- CMD write with [0] while busy: capture aborts to IDLE, snap_valid stays 0, SNAP_SEQ unchanged, reset pulse issued.
- CMD with [0] and [1] together: reset pulse at cycle t; capture starts at t+1, so all words capture post-reset values.
- Buffer reads while busy return current buffer contents (may be mixed). Software polls busy.
- Overflow:
  - A rising edge of counters_overflow sets ovf_sticky.
  - irq = ovf_sticky & irq_en.
  - W1C and set in the same cycle: set wins (same rule for snap_dropped).
- Clearing CTRL[0] mid-capture does not abort the capture.

Optional Feature:
- Macro: ARM7TDMI_PERF_AUTO_SNAPSHOT_EN.
- Defined:
  - 0x04 AUTO_PERIOD, RW, 32-bit.
  - When AUTO_PERIOD != 0 and CTRL[0]=1, a free-running counter issues an internal snapshot request every AUTO_PERIOD cycles, then reloads.
  - The request follows the same drop-if-busy rule.
  - A write to AUTO_PERIOD restarts the counter.
- Undefined: 0x04 reads 0, writes ignored, no timer logic.

Decomposition:
- arm7tdmi_pkg additions:
  - Register address localparams: PERF_CTRL_A, PERF_CMD_A, PERF_STATUS_A, PERF_SEQ_A, PERF_AUTO_A, PERF_SNAP_BASE_A.
  - CTRL/STATUS bit-position constants.
  - perf_ctrl_state_t enum {IDLE, CAPTURE, DONE}.
- Sub-module arm7tdmi_perf_snap_buffer: NUM_CNT×32 register file with one write port (FSM) and one read port (register decode).
- The counter select mux is external, at integration.

Test Plan:
- Write CTRL=0x53 → perf_enable=1, irq_en=1, perf_sample_period=5. Read back 0x53; cpu_ack exactly 1 cycle after req.
- cnt_data=0x1000+cnt_sel; write CMD=0x2 → busy for 18 cycles, perf_enable low 17 cycles, words 0x10..0x20 read 0x1000..0x1010, snap_valid=1, SNAP_SEQ=1.
- Snapshot request at capture cycle 5 → snap_dropped=1, SNAP_SEQ still increments to 1 only. W1C STATUS=0x8 clears it.
- CMD=0x1 at capture cycle 8 → perf_reset 1-cycle pulse, FSM IDLE, snap_valid=0, SNAP_SEQ unchanged.
- counters_overflow 0→1 with irq_en=1 → irq=1. Hold overflow high and W1C 0x4 → irq=0. Re-raise in the W1C cycle → irq stays 1.
- With macro: AUTO_PERIOD=100, enable → snapshots at 100-cycle intervals; SNAP_SEQ=3 after ~300 cycles. Without macro: 0x04 reads 0.
